// File: rtl/merge_sched.sv
// Round-robin control-token scheduler for the 3-input router merge stage.
// Locks onto one port for a whole packet and guards against runaway packets.
module merge_sched #(
  parameter int N_IN      = 3,
  parameter int SEL_W     = 2,
  parameter int MAX_FLITS = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  req_valid,
  input  logic [N_IN-1:0]  req_last,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic [SEL_W-1:0] ctrl_sel,
  output logic [N_IN-1:0]  grant,
  output logic             busy,
  output logic             err_overlen
);

  typedef enum logic [1:0] {IDLE, OFFER, LOCK} state_t;

  state_t           state_q, state_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic [SEL_W-1:0] ptr_q, ptr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_q, err_n;

  logic [SEL_W-1:0] c0, c1, c2, pick;
  logic [CNT_W-1:0] cnt_inc;
  logic             tail, overlen;

  function automatic logic [SEL_W-1:0] nxt(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(N_IN - 1)) ? '0 : s + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
    end
  end

  // Search order ptr, ptr+1, ptr+2 (mod 3); the last candidate needs no test
  // because pick is only used when at least one request is present.
  always_comb begin
    c0 = ptr_q;
    c1 = nxt(c0);
    c2 = nxt(c1);
    if (req_valid[c0])      pick = c0;
    else if (req_valid[c1]) pick = c1;
    else                    pick = c2;
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    cnt_inc = cnt_q + 1'b1;
    tail    = req_last[sel_q];
    overlen = (cnt_inc == CNT_W'(MAX_FLITS));
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_n = OFFER;
          sel_n   = pick;
          cnt_n   = '0;
        end
      end
      OFFER: begin
        if (ctrl_ready) begin
          cnt_n = cnt_inc;
          if (tail || overlen) begin
            state_n = IDLE;
            ptr_n   = nxt(sel_q);
            if (!tail) err_n = 1'b1;
          end else if (!req_valid[sel_q]) begin
            state_n = LOCK;
          end
        end
      end
      LOCK: begin
        if (req_valid[sel_q]) state_n = OFFER;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ctrl_valid  = (state_q == OFFER);
    busy        = (state_q != IDLE);
    ctrl_sel    = sel_q;
    err_overlen = err_q;
    grant       = '0;
    if (state_q != IDLE) grant[sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_merge_sched.sv
// Scoreboard bench for merge_sched: per-port flit sources, expected select
// queue checked by a negedge monitor, plus directed state checks.
module tb_merge_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_valid;
  logic [2:0] req_last;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic [1:0] ctrl_sel;
  logic [2:0] grant;
  logic       busy;
  logic       err_overlen;

  merge_sched #(.MAX_FLITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_sel    (ctrl_sel),
    .grant       (grant),
    .busy        (busy),
    .err_overlen (err_overlen)
  );

  always #5 clk = ~clk;

  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  bit       pq [3][$];
  bit [2:0] gap = '0;
  int       expq [$];
  int       xcyc [$];
  bit       last_xfer = 1'b0;
  int       last_sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted token is compared against the scoreboard head.
  always @(negedge clk) begin
    last_xfer = 1'b0;
    if (rst_n && ctrl_valid && ctrl_ready) begin
      last_xfer = 1'b1;
      last_sel  = int'(ctrl_sel);
      xcyc.push_back(cyc);
      if (expq.size() == 0) begin
        check("unexpected_token", int'(ctrl_sel), -1);
      end else begin
        int e;
        e = expq.pop_front();
        check("token_sel", int'(ctrl_sel), e);
        check("token_grant", int'(grant), 1 << e);
      end
    end
  end

  task automatic update_req();
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = (pq[i].size() > 0) && !gap[i];
      req_last[i]  = (pq[i].size() > 0) ? pq[i][0] : 1'b0;
    end
  endtask

  // One clock: consume the flit accepted at this edge, then refresh requests.
  task automatic step();
    @(posedge clk);
    #1;
    if (last_xfer && pq[last_sel].size() > 0) void'(pq[last_sel].pop_front());
    update_req();
  endtask

  function automatic bit sources_empty();
    return (pq[0].size() == 0) && (pq[1].size() == 0) && (pq[2].size() == 0);
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while ((expq.size() != 0 || busy || !sources_empty()) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, int'(n < 200), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl_ready = 1'b0;
    req_valid = '0;
    req_last = '0;
    step();
    step();
    @(negedge clk);
    check("rst_valid", int'(ctrl_valid), 0);
    check("rst_sel", int'(ctrl_sel), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_overlen), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All three ports request single-flit packets: order 0,1,2,0.
    ctrl_ready = 1'b1;
    xcyc.delete();
    pq[0] = '{1'b1, 1'b1};
    pq[1] = '{1'b1};
    pq[2] = '{1'b1};
    expq = '{0, 1, 2, 0};
    update_req();
    drain("rr");
    check("rr_count", xcyc.size(), 4);
    if (xcyc.size() == 4)
      for (int i = 0; i < 3; i++) check("rr_spacing", xcyc[i+1] - xcyc[i], 2);

    // ptr=1: port1 4-flit packet back-to-back, then port0.
    xcyc.delete();
    pq[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
    pq[0] = '{1'b1};
    expq = '{1, 1, 1, 1, 0};
    update_req();
    drain("pkt4");
    check("pkt4_count", xcyc.size(), 5);
    if (xcyc.size() == 5) begin
      for (int i = 0; i < 3; i++) check("pkt4_b2b", xcyc[i+1] - xcyc[i], 1);
      check("pkt4_next", xcyc[4] - xcyc[3], 2);
    end
    check("pkt4_err", int'(err_overlen), 0);

    // ptr=1: stall with ready low for 5 cycles on a port2 token.
    xcyc.delete();
    ctrl_ready = 1'b0;
    pq[2] = '{1'b1};
    expq = '{2};
    update_req();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(ctrl_valid), 1);
      check("stall_sel", int'(ctrl_sel), 2);
      step();
    end
    ctrl_ready = 1'b1;
    drain("stall");
    check("stall_xfers", xcyc.size(), 1);

    // ptr=0: lock on port2, its requests gap for 3 cycles while port0 waits.
    pq[2] = '{1'b0, 1'b0, 1'b1};
    expq = '{2, 2, 2, 0};
    update_req();
    step();
    gap[2] = 1'b1;
    pq[0] = '{1'b1};
    update_req();
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("lock_valid", int'(ctrl_valid), 0);
      check("lock_grant", int'(grant), 3'b100);
      check("lock_busy", int'(busy), 1);
    end
    gap[2] = 1'b0;
    update_req();
    drain("lock");

    // ptr=1: port0 streams without a tail; forced release after 4 flits,
    // then port1 outranks port0's remaining flit.
    pq[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    expq = '{0, 0, 0, 0, 1, 0};
    update_req();
    step();
    pq[1] = '{1'b1};
    update_req();
    step();
    @(negedge clk);
    check("overlen_early", int'(err_overlen), 0);
    drain("overlen");
    check("overlen_err", int'(err_overlen), 1);
    check("overlen_busy", int'(busy), 0);

    // Reset mid-packet, then arbitration restarts from ptr=0.
    ctrl_ready = 1'b0;
    pq[2] = '{1'b0, 1'b0, 1'b1};
    update_req();
    step();
    step();
    @(negedge clk);
    check("pre_rst_grant", int'(grant), 3'b100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) pq[i].delete();
    update_req();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(ctrl_valid), 0);
    check("mid_rst_grant", int'(grant), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(err_overlen), 0);
    ctrl_ready = 1'b1;
    pq[0] = '{1'b1};
    pq[1] = '{1'b1};
    pq[2] = '{1'b1};
    expq = '{0, 1, 2};
    update_req();
    drain("post_rst");
    check("final_queue", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merge_sched.md
Name: merge_sched

Overview:
- Clocked scheduler that generates the select/control token stream for the 3-input, 11-bit router merge stage.
- Arbitrates round-robin among three input ports with pending flits and locks onto a port for a whole multi-flit packet.
- Issues one control token per flit on a valid/ready channel. Each token is converted to the merge control channel (select 0 = port0, 1 = port1, 2 = port2).
- Guards against runaway packets with a flit-count limit.

Parameters:
- N_IN, 3, number of requesting input ports; fixed at 3 in this revision.
- SEL_W, 2, width of the select token.
- MAX_FLITS, 16, maximum flits per packet before forced release; legal range 2..255.
- CNT_W, 8, width of the packet flit counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  3  bit i high = input port i has a flit pending at the merge.
- req_last  in  3  bit i high = pending flit on port i is the packet tail; meaningful only while req_valid[i] is high.
- ctrl_valid  out  1  control token offered.
- ctrl_ready  in  1  merge control channel accepts the token.
- ctrl_sel  out  2  selected port index (0..2); never 3.
- grant  out  3  one-hot of the locked/offered port; 0 in IDLE.
- busy  out  1  high whenever state is not IDLE.
- err_overlen  out  1  sticky; set when a packet hit MAX_FLITS without a tail.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; ptr (round-robin priority pointer) = 0.
  - ctrl_valid = 0, ctrl_sel = 0, grant = 0, busy = 0, err_overlen = 0, flit count = 0.
  - Reset mid-packet abandons the lock with no further tokens.
- Handshake:
  - A token transfers in any cycle with ctrl_valid && ctrl_ready.
  - Once ctrl_valid is high, it and ctrl_sel stay stable until the transfer.
  - ctrl_ready may be high before ctrl_valid; no combinational path from ctrl_ready to ctrl_valid.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching ptr, ptr+1, ptr+2 (mod 3).
  - Register ctrl_sel = pick, grant = onehot(pick), ctrl_valid = 1, count = 0; go to OFFER.
  - Latency: token visible the cycle after req_valid is sampled.
  - With no requests, stay in IDLE.
- OFFER, on transfer: count increments, and the tail condition is req_last[ctrl_sel] sampled in the transfer cycle.
  - Tail: ptr = (ctrl_sel+1) mod 3; go to IDLE; ctrl_valid = 0, grant = 0.
  - Not tail, count+1 == MAX_FLITS: forced release; set err_overlen; ptr advances as for tail; go to IDLE.
  - Not tail and not overlength, req_valid[ctrl_sel] still high in the same cycle: stay in OFFER with ctrl_valid = 1. Back-to-back flits give one token per cycle.
  - Otherwise: go to LOCK; ctrl_valid = 0; grant held.
- LOCK:
  - Wait for req_valid[ctrl_sel]; on assertion go to OFFER (ctrl_valid = 1 the next cycle).
  - Requests on other ports are ignored while locked; no interleaving of packets.
- Round-robin rules:
  - ptr changes only at packet release.
  - A port that just released has lowest priority in the next arbitration.
  - Simultaneous requests on all three ports from ptr = 0 yield order 0, 1, 2, 0...
- Single-flit packet: req_last high on the first transfer, so it releases immediately.
- err_overlen clears only on reset.
- busy = (state != IDLE).

Test Plan:
- Reset, then req_valid = 3'b111 with req_last = 3'b111 and ctrl_ready held high: ctrl_sel sequence 0, 1, 2, 0. Each token is issued 1 cycle after IDLE re-entry, with grant one-hot matching.
- Port1 sends a 4-flit packet (req_last[1] only on the 4th) with req_valid[0] also high: four consecutive tokens with ctrl_sel = 1, then ctrl_sel = 0. ptr after release = 2.
- ctrl_ready low for 5 cycles with ctrl_valid high: ctrl_sel and ctrl_valid stable throughout; exactly one transfer when ctrl_ready rises.
- Locked on port2, req_valid[2] drops for 3 cycles while req_valid[0] is high: ctrl_valid = 0 and grant = 3'b100 in LOCK. No token for port0 until port2's tail transfers.
- MAX_FLITS = 4, port0 streams flits with no tail: after the 4th transfer, err_overlen = 1 and state returns to IDLE. Next grant goes to port1 if it is requesting.
- Assert rst_n = 0 for one cycle mid-packet: next cycle ctrl_valid = 0, grant = 0, busy = 0, err_overlen = 0. New arbitration starts from ptr = 0.
